// File: rtl/fpu_rr_arbiter_if.sv
// fpu_rr_arbiter_if: bundle of handshake signals between the FPU operation
// units, the round-robin arbiter and the shared slave port.
//
// Handshake semantics:
//   Requester side: a unit raises M_req[i] and holds it until it sees its
//   one-cycle M_ack[i] pulse. Dropping M_req[i] before the pulse withdraws
//   the request. After the pulse the unit drops M_req[i] to finish the
//   four-phase cycle.
//   Slave side: S_req stays high with a stable Select until the slave
//   answers with S_ack. The slave drops S_ack again before the arbiter
//   returns to idle.
// dbg_state / dbg_rr_ptr expose the arbiter FSM state and rotation pointer.
interface fpu_rr_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int SEL_W   = 2
);
    logic [NUM_REQ-1:0] M_req;
    logic [NUM_REQ-1:0] M_ack;
    logic               S_req;
    logic               S_ack;
    logic [SEL_W-1:0]   Select;
    logic               Busy;
    logic               Err;
    logic [1:0]         dbg_state;
    logic [SEL_W-1:0]   dbg_rr_ptr;

    // master: the arbiter's view (drives the grant side and debug state)
    modport master (
        input  M_req, S_ack,
        output M_ack, S_req, Select, Busy, Err, dbg_state, dbg_rr_ptr
    );

    // slave: the environment's view (operation units plus shared slave)
    modport slave (
        output M_req, S_ack,
        input  M_ack, S_req, Select, Busy, Err, dbg_state, dbg_rr_ptr
    );
endinterface

// File: rtl/fpu_rr_arbiter.sv
// fpu_rr_arbiter: round-robin arbiter sharing one FPU slave port among
// NUM_REQ operation units. Every output is registered.
// Optional stall watchdog: define FPU_ARB_TIMEOUT_EN to abort a grant that
// waits TIMEOUT_CYC cycles for S_ack; Err pulses for one cycle on abort.
// Without the macro Err is constant 0 and a grant waits indefinitely.
module fpu_rr_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int SEL_W       = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              CLK,
    input  logic              RST,
    fpu_rr_arbiter_if.master  bus
);

    // One extra bit so index sums below 2*NUM_REQ never overflow before wrap.
    localparam int IW = SEL_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   rr_q, rr_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [NUM_REQ-1:0] m_ack_q, m_ack_d;
    logic               s_req_q, s_req_d;
    logic               busy_q, busy_d;
    logic [SEL_W-1:0]   winner;
    logic [SEL_W-1:0]   scan_idx;
    logic               any_req;
    logic               req_sel;

`ifdef FPU_ARB_TIMEOUT_EN
    logic [7:0]         wd_q, wd_d;
    logic               err_q, err_d;
    logic               wd_hit;
`endif

    // Elaboration guard on the parameter ranges and the Select width.
    if (NUM_REQ < 1 || NUM_REQ > 8 ||
        SEL_W != ((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1) ||
        TIMEOUT_CYC < 2 || TIMEOUT_CYC > 255) begin : g_bad_params
        $error("fpu_rr_arbiter: illegal NUM_REQ/SEL_W/TIMEOUT_CYC combination");
    end

    // Reduce a requester index sum (< 2*NUM_REQ) modulo NUM_REQ.
    function automatic logic [SEL_W-1:0] mod_req(input logic [IW-1:0] v);
        logic [IW-1:0] r;
        r = v;
        if (r >= IW'(NUM_REQ)) begin
            r = r - IW'(NUM_REQ);
        end
        return r[SEL_W-1:0];
    endfunction

    assign any_req = |bus.M_req;
    assign req_sel = bus.M_req[sel_q];

`ifdef FPU_ARB_TIMEOUT_EN
    assign wd_hit = (wd_q == 8'(TIMEOUT_CYC - 1));
`endif

    // Round-robin scan: walk from the farthest offset back to rr_ptr so the
    // closest set bit at or after rr_ptr is the last one written.
    always_comb begin
        winner   = '0;
        scan_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            scan_idx = mod_req({1'b0, rr_q} + IW'(k));
            if (bus.M_req[scan_idx]) begin
                winner = scan_idx;
            end
        end
    end

    // Next-state and next-output logic for the IDLE/GRANT/DONE controller.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        sel_d   = sel_q;
        s_req_d = 1'b0;
        m_ack_d = '0;
        busy_d  = busy_q;
`ifdef FPU_ARB_TIMEOUT_EN
        wd_d    = wd_q;
        err_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = GRANT;
                    sel_d   = winner;
                    rr_d    = mod_req({1'b0, winner} + IW'(1));
                    s_req_d = 1'b1;
                    busy_d  = 1'b1;
`ifdef FPU_ARB_TIMEOUT_EN
                    wd_d    = 8'd0;
`endif
                end
            end
            GRANT: begin
                // Withdrawal beats a late S_ack; S_ack beats the watchdog.
                if (!req_sel) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else if (bus.S_ack) begin
                    state_d        = DONE;
                    m_ack_d[sel_q] = 1'b1;
                end
`ifdef FPU_ARB_TIMEOUT_EN
                else if (wd_hit) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                end
`endif
                else begin
                    s_req_d = 1'b1;
`ifdef FPU_ARB_TIMEOUT_EN
                    wd_d    = wd_q + 8'd1;
`endif
                end
            end
            DONE: begin
                // Four-phase completion: both sides must release first.
                if (!req_sel && !bus.S_ack) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            rr_q    <= '0;
            sel_q   <= '0;
            s_req_q <= 1'b0;
            m_ack_q <= '0;
            busy_q  <= 1'b0;
`ifdef FPU_ARB_TIMEOUT_EN
            wd_q    <= 8'd0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            sel_q   <= sel_d;
            s_req_q <= s_req_d;
            m_ack_q <= m_ack_d;
            busy_q  <= busy_d;
`ifdef FPU_ARB_TIMEOUT_EN
            wd_q    <= wd_d;
            err_q   <= err_d;
`endif
        end
    end

    assign bus.M_ack      = m_ack_q;
    assign bus.S_req      = s_req_q;
    assign bus.Select     = sel_q;
    assign bus.Busy       = busy_q;
    assign bus.dbg_state  = state_q;
    assign bus.dbg_rr_ptr = rr_q;
`ifdef FPU_ARB_TIMEOUT_EN
    assign bus.Err        = err_q;
`else
    assign bus.Err        = 1'b0;
`endif

endmodule

// File: tb/tb_fpu_rr_arbiter.sv
// tb_fpu_rr_arbiter: vector table, hand-written corner sequences and random
// stimulus for fpu_rr_arbiter (NUM_REQ=4, TIMEOUT_CYC=8).
module tb_fpu_rr_arbiter;

    localparam int N  = 4;
    localparam int SW = 2;
    localparam int TO = 8;
    localparam int W  = 13;
`ifdef FPU_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    fpu_rr_arbiter_if #(.NUM_REQ(N), .SEL_W(SW)) bus ();

    fpu_rr_arbiter #(.NUM_REQ(N), .SEL_W(SW), .TIMEOUT_CYC(TO)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    // Reference model: phase 0=idle, 1=granted, 2=done.
    int         m_phase = 0;
    int         m_ptr   = 0;
    int         m_sel   = 0;
    int         m_wait  = 0;
    logic       m_sreq  = 1'b0;
    logic       m_busy  = 1'b0;
    logic       m_err   = 1'b0;
    logic [3:0] m_ack   = 4'b0;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       ack;
        logic [3:0] e_mack;
        logic       e_sreq;
        logic [1:0] e_sel;
        logic       e_busy;
        logic [1:0] e_state;
        logic [1:0] e_rr;
    } vec_t;

    vec_t vecs[21];

    function automatic logic [W-1:0] mk_bundle(input logic [3:0] a, input logic s,
                                               input logic [1:0] sel, input logic b,
                                               input logic e, input logic [1:0] st,
                                               input logic [1:0] rr);
        return {a, s, sel, b, e, st, rr};
    endfunction

    function automatic logic [W-1:0] dut_bundle();
        return {bus.M_ack, bus.S_req, bus.Select, bus.Busy, bus.Err,
                bus.dbg_state, bus.dbg_rr_ptr};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock edge of the arbiter rules, applied to the model.
    task automatic model_step(input logic r, input logic [3:0] req, input logic ack);
        int w;
        m_ack = 4'b0;
        m_err = 1'b0;
        if (r) begin
            m_phase = 0; m_ptr = 0; m_sel = 0; m_wait = 0;
            m_sreq = 1'b0; m_busy = 1'b0;
        end else if (m_phase == 0) begin
            m_sreq = 1'b0;
            w = -1;
            for (int k = 0; k < N; k++) begin
                if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            end
            if (w >= 0) begin
                m_sel = w; m_ptr = (w + 1) % N;
                m_sreq = 1'b1; m_busy = 1'b1; m_phase = 1; m_wait = 0;
            end
        end else if (m_phase == 1) begin
            if (!req[m_sel]) begin
                m_sreq = 1'b0; m_busy = 1'b0; m_phase = 0;
            end else if (ack) begin
                m_sreq = 1'b0; m_ack[m_sel] = 1'b1; m_phase = 2;
            end else if (TO_EN && m_wait == TO - 1) begin
                m_sreq = 1'b0; m_err = 1'b1; m_busy = 1'b0; m_phase = 0;
            end else begin
                m_wait++;
            end
        end else begin
            if (!req[m_sel] && !ack) begin
                m_busy = 1'b0; m_phase = 0;
            end
        end
        exp_q.push_back(mk_bundle(m_ack, m_sreq, 2'(m_sel), m_busy, m_err,
                                  2'(m_phase), 2'(m_ptr)));
    endtask

    task automatic sb_check();
        logic [W-1:0] e;
        if (exp_q.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check("model", 32'(dut_bundle()), 32'(e));
        end
        check("ack_onehot", 32'($onehot0(bus.M_ack)), 32'd1);
        check("ack_sreq_excl", 32'(bus.S_req & (|bus.M_ack)), 32'd0);
    endtask

    // ---------------- driver ----------------
    // Called with the clock low; applies inputs for the next rising edge.
    task automatic cycle(input logic r, input logic [3:0] req, input logic ack);
        RST        = r;
        bus.M_req  = req;
        bus.S_ack  = ack;
        @(posedge CLK);
        model_step(r, req, ack);
        @(negedge CLK);
        sb_check();
    endtask

    // Global time limit so the run always ends.
    initial begin
        #400000;
        $display("FAIL time_limit actual=expired required=finished");
        $fatal(1, "time limit");
    end

    initial begin
        logic [3:0] rq;
        logic       ak;
        logic       rs;
        int         acks;
        int         idx;

        bus.M_req = 4'b0;
        bus.S_ack = 1'b0;

        // rst, req, ack -> M_ack, S_req, Select, Busy, state, rr_ptr
        vecs[0]  = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0};
        vecs[1]  = '{1'b0, 4'b0100, 1'b0, 4'b0000, 1'b1, 2'd2, 1'b1, 2'd1, 2'd3};
        vecs[2]  = '{1'b0, 4'b0100, 1'b0, 4'b0000, 1'b1, 2'd2, 1'b1, 2'd1, 2'd3};
        vecs[3]  = '{1'b0, 4'b0100, 1'b0, 4'b0000, 1'b1, 2'd2, 1'b1, 2'd1, 2'd3};
        vecs[4]  = '{1'b0, 4'b0100, 1'b1, 4'b0100, 1'b0, 2'd2, 1'b1, 2'd2, 2'd3};
        vecs[5]  = '{1'b0, 4'b0100, 1'b0, 4'b0000, 1'b0, 2'd2, 1'b1, 2'd2, 2'd3};
        vecs[6]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd2, 1'b0, 2'd0, 2'd3};
        vecs[7]  = '{1'b0, 4'b0010, 1'b0, 4'b0000, 1'b1, 2'd1, 1'b1, 2'd1, 2'd2};
        vecs[8]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd1, 1'b0, 2'd0, 2'd2};
        vecs[9]  = '{1'b0, 4'b0111, 1'b0, 4'b0000, 1'b1, 2'd2, 1'b1, 2'd1, 2'd3};
        vecs[10] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd2, 1'b0, 2'd0, 2'd3};
        vecs[11] = '{1'b0, 4'b1000, 1'b0, 4'b0000, 1'b1, 2'd3, 1'b1, 2'd1, 2'd0};
        vecs[12] = '{1'b1, 4'b1000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0};
        vecs[13] = '{1'b0, 4'b1001, 1'b0, 4'b0000, 1'b1, 2'd0, 1'b1, 2'd1, 2'd1};
        vecs[14] = '{1'b0, 4'b0001, 1'b1, 4'b0001, 1'b0, 2'd0, 1'b1, 2'd2, 2'd1};
        vecs[15] = '{1'b0, 4'b0001, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b1, 2'd2, 2'd1};
        vecs[16] = '{1'b0, 4'b0011, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b1, 2'd2, 2'd1};
        vecs[17] = '{1'b0, 4'b0010, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b1, 2'd2, 2'd1};
        vecs[18] = '{1'b0, 4'b0010, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 2'd0, 2'd1};
        vecs[19] = '{1'b0, 4'b0010, 1'b0, 4'b0000, 1'b1, 2'd1, 1'b1, 2'd1, 2'd2};
        vecs[20] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd1, 1'b0, 2'd0, 2'd2};

        // ---- directed table: single request, withdrawal, reset, four-phase ----
        for (int i = 0; i < 21; i++) begin
            cycle(vecs[i].rst, vecs[i].req, vecs[i].ack);
            check($sformatf("vec%0d", i), 32'(dut_bundle()),
                  32'(mk_bundle(vecs[i].e_mack, vecs[i].e_sreq, vecs[i].e_sel,
                                vecs[i].e_busy, 1'b0, vecs[i].e_state, vecs[i].e_rr)));
        end

        // ---- contention rotation: all four requesting, ack echoes S_req ----
        cycle(1'b1, 4'b0000, 1'b0);
        acks = 0;
        for (int c = 0; c < 100 && acks < 5; c++) begin
            cycle(1'b0, 4'b1111 & ~bus.M_ack, bus.S_req);
            if (bus.M_ack != 4'b0) begin
                idx = 0;
                for (int b = 0; b < N; b++) if (bus.M_ack[b]) idx = b;
                check($sformatf("rot_order%0d", acks), 32'(idx), 32'(acks % N));
                acks++;
            end
        end
        check("rot_count", 32'(acks), 32'd5);

        // ---- long stall: watchdog abort, or indefinite wait without it ----
        cycle(1'b1, 4'b0000, 1'b0);
        cycle(1'b0, 4'b0001, 1'b0);
        check("stall_grant", 32'({bus.S_req, bus.Select}), 32'({1'b1, 2'd0}));
        for (int c = 0; c < TO - 1; c++) begin
            cycle(1'b0, 4'b0001, 1'b0);
            check("stall_hold", 32'({bus.S_req, bus.Err}), 32'({1'b1, 1'b0}));
        end
        cycle(1'b0, 4'b0001, 1'b0);
        if (TO_EN) begin
            check("to_fire", 32'({bus.S_req, bus.Err, bus.M_ack, bus.dbg_state}),
                  32'({1'b0, 1'b1, 4'b0000, 2'd0}));
        end else begin
            check("no_to_hold", 32'({bus.S_req, bus.Err, bus.M_ack, bus.dbg_state}),
                  32'({1'b1, 1'b0, 4'b0000, 2'd1}));
        end
        cycle(1'b0, 4'b0000, 1'b0);
        check("err_width", 32'({bus.Err, bus.M_ack}), 32'({1'b0, 4'b0000}));

        // ---- S_ack on the watchdog limit edge wins ----
        cycle(1'b1, 4'b0000, 1'b0);
        cycle(1'b0, 4'b0001, 1'b0);
        for (int c = 0; c < TO - 1; c++) cycle(1'b0, 4'b0001, 1'b0);
        cycle(1'b0, 4'b0001, 1'b1);
        check("limit_ack", 32'({bus.M_ack, bus.Err, bus.S_req, bus.dbg_state}),
              32'({4'b0001, 1'b0, 1'b0, 2'd2}));
        cycle(1'b0, 4'b0000, 1'b0);
        check("limit_idle", 32'({bus.Busy, bus.dbg_state}), 32'({1'b0, 2'd0}));

        // ---- randomized traffic against the reference model ----
        rq = 4'b0;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 7) == 0) rq[b] = ~rq[b];
            end
            if (((c / 64) % 4) == 3) ak = 1'b0;
            else ak = ($urandom_range(0, 2) == 0);
            rs = ($urandom_range(0, 299) == 0);
            cycle(rs, rq, ak);
        end

        check("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
